// File: rtl/uart_sched_if.sv
// Register port of the memory-mapped UART: one master drives sel/we/addr/wdata,
// the UART answers reads on rdata one cycle after the select.
interface uart_sched_if;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output sel,
    output we,
    output addr,
    output wdata,
    input  rdata
  );

  modport slave (
    input  sel,
    input  we,
    input  addr,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/uart_sched.sv
// Sole bus master of the UART: programs the baud divisor, polls SR, round-robins
// NREQ byte requesters onto the transmitter and drains received bytes to a stream.
module uart_sched #(
  parameter int unsigned NREQ     = 2,
  parameter logic [31:0] BAUD_DIV = 32'd433
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [8*NREQ-1:0] req_data_i,
  output logic [NREQ-1:0]   req_ready_o,
  output logic [7:0]        rx_data_o,
  output logic              rx_fe_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  uart_sched_if.master      uart
);

  localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] AddrOdr  = 2'd0;
  localparam logic [1:0] AddrIdr  = 2'd1;
  localparam logic [1:0] AddrBaud = 2'd2;
  localparam logic [1:0] AddrSr   = 2'd3;

  typedef enum logic [2:0] {
    StInit, StPoll, StPollWait, StWrOdr, StRdIdr, StRdWait, StClrRx
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      sr_q;
  logic [GW-1:0]   grant_q, last_grant_q, grant_next;
  logic            grant_found;
  int unsigned     idx;
  logic [7:0]      rx_data_q;
  logic            rx_fe_q, rx_valid_q;

  // First valid requester after last_grant, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_next  = last_grant_q;
    idx         = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant_q) + k) % NREQ;
      if (!grant_found && req_valid_i[idx]) begin
        grant_found = 1'b1;
        grant_next  = GW'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    uart.sel    = 1'b0;
    uart.we     = 1'b0;
    uart.addr   = 2'd0;
    uart.wdata  = 32'd0;
    req_ready_o = '0;
    unique case (state_q)
      StInit: begin
        // INIT is also the reset state; keep the bus quiet while reset is held.
        if (rst_i) begin
          uart.sel   = 1'b1;
          uart.we    = 1'b1;
          uart.addr  = AddrBaud;
          uart.wdata = BAUD_DIV;
        end
        state_d = StPoll;
      end
      StPoll: begin
        uart.sel  = 1'b1;
        uart.addr = AddrSr;
        state_d   = StPollWait;
      end
      StPollWait: begin
        if (uart.rdata[1] && !rx_valid_q) begin
          state_d = StRdIdr;
        end else if (!uart.rdata[0] && grant_found) begin
          state_d = StWrOdr;
        end else begin
          state_d = StPoll;
        end
      end
      StWrOdr: begin
        uart.sel             = 1'b1;
        uart.we              = 1'b1;
        uart.addr            = AddrOdr;
        uart.wdata           = {24'd0, req_data_i[8*grant_q +: 8]};
        req_ready_o[grant_q] = 1'b1;
        state_d              = StPoll;
      end
      StRdIdr: begin
        uart.sel  = 1'b1;
        uart.addr = AddrIdr;
        state_d   = StRdWait;
      end
      StRdWait: state_d = StClrRx;
      StClrRx: begin
        uart.sel  = 1'b1;
        uart.we   = 1'b1;
        uart.addr = AddrSr;
        state_d   = StPoll;
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= StInit;
      sr_q         <= 3'd0;
      grant_q      <= '0;
      last_grant_q <= GW'(NREQ - 1);
      rx_data_q    <= 8'd0;
      rx_fe_q      <= 1'b0;
      rx_valid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StPollWait) begin
        sr_q    <= uart.rdata[2:0];
        grant_q <= grant_next;
      end
      if (state_q == StWrOdr) begin
        last_grant_q <= grant_q;
      end
      if (state_q == StRdWait) begin
        rx_data_q  <= uart.rdata[7:0];
        rx_fe_q    <= sr_q[2];
        rx_valid_q <= 1'b1;
      end else if (rx_valid_q && rx_ready_i) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_data_o  = rx_data_q;
  assign rx_fe_o    = rx_fe_q;
  assign rx_valid_o = rx_valid_q;

endmodule

// File: tb/tb_uart_sched.sv
// Directed bench for uart_sched with three requesters and a hand-driven UART register model.
module tb_uart_sched;
  localparam int unsigned NREQ = 3;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        rx_data;
  logic              rx_fe, rx_valid, rx_ready;
  logic              busy, rdy, fe;
  logic [7:0]        idr;
  int                total = 0;
  int                bad = 0;

  uart_sched_if bus ();

  uart_sched #(.NREQ(NREQ), .BAUD_DIV(32'd433)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .rx_data_o   (rx_data),
    .rx_fe_o     (rx_fe),
    .rx_valid_o  (rx_valid),
    .rx_ready_i  (rx_ready),
    .uart        (bus.master)
  );

  always #5 clk_i = ~clk_i;

  // UART read port: registered answer to a read select.
  always @(posedge clk_i) begin
    if (bus.sel && !bus.we) begin
      bus.rdata <= (bus.addr == 2'd3) ? {29'd0, fe, rdy, busy} :
                   (bus.addr == 2'd1) ? {24'd0, idr} : 32'd0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic nxt();
    @(negedge clk_i);
  endtask

  task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic s, input logic w, input logic [1:0] a,
                         input logic [31:0] d);
    chk(tag, {bus.sel, bus.we, bus.addr, bus.wdata}, {s, w, a, d});
  endtask

  task automatic chk_rx(input string tag, input logic v, input logic f, input logic [7:0] d);
    chk(tag, {26'd0, rx_valid, rx_fe, rx_data}, {26'd0, v, f, d});
  endtask

  task automatic chk_rdy(input string tag, input logic [NREQ-1:0] r);
    chk(tag, 36'(req_ready), 36'(r));
  endtask

  // Starts and ends at a POLL cycle with busy=0; one grant plus the busy wait after it.
  task automatic tx_grant(input string tag, input int unsigned g, input logic [7:0] b);
    chk_bus({tag, "_poll"}, 1'b1, 1'b0, 2'd3, 32'd0);
    nxt();
    chk_bus({tag, "_pw"}, 1'b0, 1'b0, 2'd0, 32'd0);
    nxt();
    chk_bus({tag, "_wr"}, 1'b1, 1'b1, 2'd0, {24'd0, b});
    chk_rdy({tag, "_rdy"}, NREQ'(1 << g));
    busy = 1'b1;
    nxt();
    chk_rdy({tag, "_rdy_off"}, '0);
    chk_bus({tag, "_poll_busy"}, 1'b1, 1'b0, 2'd3, 32'd0);
    nxt();
    nxt();
    chk_bus({tag, "_no_wr"}, 1'b1, 1'b0, 2'd3, 32'd0);
    busy = 1'b0;
  endtask

  initial begin
    req_valid = '0;
    req_data  = '0;
    rx_ready  = 1'b0;
    busy      = 1'b0;
    rdy       = 1'b0;
    fe        = 1'b0;
    idr       = 8'd0;
    nxt();
    nxt();
    chk_bus("rst_bus", 1'b0, 1'b0, 2'd0, 32'd0);
    chk_rx("rst_rx", 1'b0, 1'b0, 8'd0);
    chk_rdy("rst_rdy", '0);

    rst_i = 1'b1;
    #1;
    chk_bus("init_baud", 1'b1, 1'b1, 2'd2, 32'd433);
    nxt(); chk_bus("poll0", 1'b1, 1'b0, 2'd3, 32'd0);
    nxt(); chk_bus("pwait0", 1'b0, 1'b0, 2'd0, 32'd0);
    nxt(); chk_bus("poll1", 1'b1, 1'b0, 2'd3, 32'd0);
    nxt(); chk_bus("pwait1", 1'b0, 1'b0, 2'd0, 32'd0);
    nxt();

    req_valid = 3'b111;
    req_data  = {8'hC3, 8'hB2, 8'hA1};
    tx_grant("rr0", 0, 8'hA1);
    tx_grant("rr1", 1, 8'hB2);
    tx_grant("rr2", 2, 8'hC3);
    tx_grant("rr3", 0, 8'hA1);
    tx_grant("rr4", 1, 8'hB2);
    tx_grant("rr5", 2, 8'hC3);

    req_valid = 3'b001;
    req_data  = {8'hC3, 8'hB2, 8'h55};
    tx_grant("single0", 0, 8'h55);
    tx_grant("single1", 0, 8'h55);

    req_valid = '0;
    rdy = 1'b1; idr = 8'h3C; fe = 1'b0;
    nxt(); chk_bus("rx_pw", 1'b0, 1'b0, 2'd0, 32'd0);
    nxt(); chk_bus("rx_idr", 1'b1, 1'b0, 2'd1, 32'd0);
    nxt(); chk_bus("rx_wait", 1'b0, 1'b0, 2'd0, 32'd0);
    chk_rx("rx_pre", 1'b0, 1'b0, 8'd0);
    nxt(); chk_rx("rx_3c", 1'b1, 1'b0, 8'h3C);
    chk_bus("rx_clr", 1'b1, 1'b1, 2'd3, 32'd0);
    rdy = 1'b0;
    nxt();

    // Unconsumed RX byte blocks further IDR reads; TX still proceeds.
    rdy = 1'b1; idr = 8'h77;
    req_valid = 3'b001;
    req_data  = {8'hC3, 8'hB2, 8'h5A};
    tx_grant("tx_blk", 0, 8'h5A);
    chk_rx("rx_held", 1'b1, 1'b0, 8'h3C);

    req_data = {8'hC3, 8'hB2, 8'h66};
    rx_ready = 1'b1;
    nxt(); chk_rx("rx_drain", 1'b0, 1'b0, 8'h3C);
    chk_bus("prio_pw", 1'b0, 1'b0, 2'd0, 32'd0);
    nxt(); chk_bus("prio_idr", 1'b1, 1'b0, 2'd1, 32'd0);
    chk_rdy("prio_nordy", '0);
    nxt();
    nxt(); chk_rx("rx_77", 1'b1, 1'b0, 8'h77);
    chk_bus("prio_clr", 1'b1, 1'b1, 2'd3, 32'd0);
    rdy = 1'b0;
    nxt(); chk_rx("rx_acc", 1'b0, 1'b0, 8'h77);
    chk_bus("prio_poll", 1'b1, 1'b0, 2'd3, 32'd0);
    nxt();
    nxt(); chk_bus("prio_wr", 1'b1, 1'b1, 2'd0, 32'h66);
    chk_rdy("prio_rdy", 3'b001);
    busy = 1'b1;
    req_valid = '0;
    nxt();
    busy = 1'b0;

    rdy = 1'b1; idr = 8'hF0; fe = 1'b1;
    nxt();
    nxt(); chk_bus("fe_idr", 1'b1, 1'b0, 2'd1, 32'd0);
    nxt();
    nxt(); chk_rx("rx_fe", 1'b1, 1'b1, 8'hF0);
    rdy = 1'b0; fe = 1'b0;
    nxt();

    rx_ready = 1'b0;
    rdy = 1'b1; idr = 8'h3C;
    nxt();
    nxt(); chk_bus("rr_idr", 1'b1, 1'b0, 2'd1, 32'd0);
    nxt(); chk_bus("rr_wait", 1'b0, 1'b0, 2'd0, 32'd0);
    rst_i = 1'b0;
    #1;
    chk_bus("rst2_bus", 1'b0, 1'b0, 2'd0, 32'd0);
    chk_rx("rst2_rx", 1'b0, 1'b0, 8'd0);
    chk_rdy("rst2_rdy", '0);
    nxt(); chk_bus("rst2_hold", 1'b0, 1'b0, 2'd0, 32'd0);
    rst_i = 1'b1;
    #1;
    chk_bus("reinit_baud", 1'b1, 1'b1, 2'd2, 32'd433);
    nxt(); chk_bus("reinit_poll", 1'b1, 1'b0, 2'd3, 32'd0);
    nxt();
    nxt(); chk_bus("reread_idr", 1'b1, 1'b0, 2'd1, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
